// File: rtl/mips32_mem_pkg.sv
// Shared types and defaults for the MIPS32 single-port memory arbiter.
//   AW_DEF / DW_DEF : default word-address and data widths
//   owner_t         : which requester holds (or wins) the memory port
//   arb_state_t     : arbiter FSM states
package mips32_mem_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2,
    OWN_LD   = 2'd3
  } owner_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mips32_mem_pick.sv
// Combinational priority picker for the memory arbiter.
// Ports:
//   ld_elig, dm_elig, if_elig : eligibility of loader, data and fetch
//   if_override               : fetch has been starved long enough to beat dm
//   winner                    : selected owner (OWN_NONE when nobody is eligible)
// Priority is ld > dm > if; the override lifts fetch above dm but never above ld.
module mips32_mem_pick
  import mips32_mem_pkg::*;
(
  input  logic   ld_elig,
  input  logic   dm_elig,
  input  logic   if_elig,
  input  logic   if_override,
  output owner_t winner
);

  always_comb begin
    winner = OWN_NONE;
    if (ld_elig)                       winner = OWN_LD;
    else if (if_elig && if_override)   winner = OWN_IF;
    else if (dm_elig)                  winner = OWN_DM;
    else if (if_elig)                  winner = OWN_IF;
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch (if), MEM-stage data
// access (dm) and the host program loader (ld, only while the core is halted).
// Ports:
//   clk1, rst                 : clock, synchronous active-high reset
//   halted                    : core HALTED flag, gates loader eligibility
//   if_*  / dm_* / ld_*       : requester interfaces (req/we/addr/wdata in,
//                               gnt/rvalid/rdata out); fetch is read-only
//   mem_en/we/addr/wdata      : command to the synchronous memory
//   mem_rdata                 : read data, valid MEM_LAT cycles after a read
//   busy                      : a read is outstanding (not yet in its rvalid cycle)
//
// Handshake: a requester raises *_req with stable addr/wdata and holds it until
// it sees *_gnt, which is asserted combinationally in the cycle the request is
// accepted (the requester samples it in that same cycle). Writes finish in the
// grant cycle. A read returns exactly one *_rvalid pulse MEM_LAT cycles after
// its grant; *_rdata is meaningful only while *_rvalid is high.
module mips32_mem_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          halted,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t    state, state_nx;
  logic [LW-1:0] lat_cnt, lat_cnt_nx;
  owner_t        owner, owner_nx;
  logic [SW-1:0] starve_cnt, starve_cnt_nx;
  logic [DW-1:0] if_hold, dm_hold, ld_hold;

  owner_t pick;
  owner_t winner;
  logic   rd_done;
  logic   can_grant;
  logic   if_override;

  assign if_override = if_req && (starve_cnt == SW'(STARVE_MAX));

  mips32_mem_pick u_pick (
    .ld_elig     (ld_req && halted),
    .dm_elig     (dm_req),
    .if_elig     (if_req),
    .if_override (if_override),
    .winner      (pick)
  );

  always_ff @(posedge clk1) begin
    if (rst) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      owner      <= OWN_NONE;
      starve_cnt <= '0;
      if_hold    <= '0;
      dm_hold    <= '0;
      ld_hold    <= '0;
    end else begin
      state      <= state_nx;
      lat_cnt    <= lat_cnt_nx;
      owner      <= owner_nx;
      starve_cnt <= starve_cnt_nx;
      if (if_rvalid) if_hold <= mem_rdata;
      if (dm_rvalid) dm_hold <= mem_rdata;
      if (ld_rvalid) ld_hold <= mem_rdata;
    end
  end

  always_comb begin
    // Final cycle of an outstanding read: data returns and the port frees up.
    // Reset suppresses it so an abandoned read never reports rvalid.
    rd_done   = !rst && (state == ST_RD_WAIT) && (lat_cnt == '0);
    can_grant = !rst && ((state == ST_IDLE) || rd_done);
    winner    = can_grant ? pick : OWN_NONE;

    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    ld_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (winner)
      OWN_IF: begin
        if_gnt   = 1'b1;
        mem_en   = 1'b1;
        mem_addr = if_addr;
      end
      OWN_DM: begin
        dm_gnt    = 1'b1;
        mem_en    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end
      OWN_LD: begin
        ld_gnt    = 1'b1;
        mem_en    = 1'b1;
        mem_we    = ld_we;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
      end
      default: ;
    endcase

    if_rvalid = rd_done && (owner == OWN_IF);
    dm_rvalid = rd_done && (owner == OWN_DM);
    ld_rvalid = rd_done && (owner == OWN_LD);
    if_rdata  = if_rvalid ? mem_rdata : if_hold;
    dm_rdata  = dm_rvalid ? mem_rdata : dm_hold;
    ld_rdata  = ld_rvalid ? mem_rdata : ld_hold;
    busy      = !rst && (state == ST_RD_WAIT) && (lat_cnt != '0);

    state_nx   = state;
    lat_cnt_nx = lat_cnt;
    owner_nx   = owner;
    if ((state == ST_RD_WAIT) && (lat_cnt != '0)) lat_cnt_nx = lat_cnt - LW'(1);
    if (rd_done) begin
      state_nx = ST_IDLE;
      owner_nx = OWN_NONE;
    end
    // A read granted in the rvalid cycle chains straight into the next wait.
    if (mem_en && !mem_we) begin
      state_nx   = ST_RD_WAIT;
      lat_cnt_nx = LW'(MEM_LAT - 1);
      owner_nx   = winner;
    end

    starve_cnt_nx = starve_cnt;
    if (!if_req || (winner == OWN_IF))
      starve_cnt_nx = '0;
    else if ((winner == OWN_DM) && (starve_cnt != SW'(STARVE_MAX)))
      starve_cnt_nx = starve_cnt + SW'(1);
  end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Bench for mips32_mem_arbiter: three instances (MEM_LAT = 1, 3, 4), each with
// its own memory model. Table vectors, directed corner sequences, then random
// traffic checked against a cycle-count based reference model.
module tb_mips32_mem_arbiter;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic        rst [3];
  logic        halted [3];
  logic        if_req [3];
  logic [9:0]  if_addr [3];
  logic        if_gnt [3], if_rvalid [3];
  logic [31:0] if_rdata [3];
  logic        dm_req [3], dm_we [3];
  logic [9:0]  dm_addr [3];
  logic [31:0] dm_wdata [3];
  logic        dm_gnt [3], dm_rvalid [3];
  logic [31:0] dm_rdata [3];
  logic        ld_req [3], ld_we [3];
  logic [9:0]  ld_addr [3];
  logic [31:0] ld_wdata [3];
  logic        ld_gnt [3], ld_rvalid [3];
  logic [31:0] ld_rdata [3];
  logic        mem_en [3], mem_we [3];
  logic [9:0]  mem_addr [3];
  logic [31:0] mem_wdata [3], mem_rdata [3];
  logic        busy [3];
  logic        mem_init;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] init_val(input int a);
    return 32'hA5000000 ^ (32'(a) * 32'h00010003);
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int LAT = (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    logic [31:0] mem [1024];
    logic [31:0] rpipe [4];

    mips32_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(4)) u_dut (
      .clk1(clk1), .rst(rst[k]), .halted(halted[k]),
      .if_req(if_req[k]), .if_addr(if_addr[k]), .if_gnt(if_gnt[k]),
      .if_rvalid(if_rvalid[k]), .if_rdata(if_rdata[k]),
      .dm_req(dm_req[k]), .dm_we(dm_we[k]), .dm_addr(dm_addr[k]), .dm_wdata(dm_wdata[k]),
      .dm_gnt(dm_gnt[k]), .dm_rvalid(dm_rvalid[k]), .dm_rdata(dm_rdata[k]),
      .ld_req(ld_req[k]), .ld_we(ld_we[k]), .ld_addr(ld_addr[k]), .ld_wdata(ld_wdata[k]),
      .ld_gnt(ld_gnt[k]), .ld_rvalid(ld_rvalid[k]), .ld_rdata(ld_rdata[k]),
      .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]),
      .mem_wdata(mem_wdata[k]), .mem_rdata(mem_rdata[k]), .busy(busy[k])
    );

    // Synchronous memory: read data emerges LAT cycles after the command.
    always @(posedge clk1) begin
      if (mem_init) begin
        for (int a = 0; a < 1024; a++) mem[a] <= init_val(a);
      end else if (mem_en[k] && mem_we[k]) begin
        mem[mem_addr[k]] <= mem_wdata[k];
      end
      rpipe[0] <= (mem_en[k] && !mem_we[k]) ? mem[mem_addr[k]] : 32'hdeadbeef;
      for (int i = 1; i < 4; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata[k] = rpipe[LAT-1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    @(posedge clk1); #1;
  endtask

  task automatic sample();
    @(negedge clk1);
  endtask

  task automatic clr(input int k);
    if_req[k] = 0; dm_req[k] = 0; ld_req[k] = 0;
    dm_we[k] = 0; ld_we[k] = 0;
  endtask

  task automatic reset_one(input int k);
    drive(); rst[k] = 1; clr(k);
    drive(); drive(); rst[k] = 0;
  endtask

  task automatic pulse_mem_init();
    drive(); mem_init = 1;
    drive(); mem_init = 0;
  endtask

  // ---------------- table-driven single-cycle grant vectors (MEM_LAT=1) ------
  typedef struct {
    logic       halted, ld_req, ld_we, dm_req, dm_we, if_req;
    logic [2:0] gnt;      // {ld, dm, if}
    logic       mem_en, mem_we;
    logic [9:0] mem_addr;
  } vec_t;

  task automatic run_table();
    vec_t tab [10];
    logic [31:0] exp_wd;
    tab[0] = '{0,0,0,0,0,0, 3'b000, 0,0, 10'd0};
    tab[1] = '{0,0,0,0,0,1, 3'b001, 1,0, 10'd1};
    tab[2] = '{0,0,0,1,1,0, 3'b010, 1,1, 10'd2};
    tab[3] = '{0,0,0,1,1,1, 3'b010, 1,1, 10'd2};
    tab[4] = '{0,1,1,0,0,0, 3'b000, 0,0, 10'd0};
    tab[5] = '{1,1,1,0,0,0, 3'b100, 1,1, 10'd3};
    tab[6] = '{1,1,0,1,1,1, 3'b100, 1,0, 10'd3};
    tab[7] = '{0,1,1,1,0,1, 3'b010, 1,0, 10'd2};
    tab[8] = '{0,1,1,0,0,1, 3'b001, 1,0, 10'd1};
    tab[9] = '{0,0,0,1,0,0, 3'b010, 1,0, 10'd2};
    if_addr[0] = 1; dm_addr[0] = 2; ld_addr[0] = 3;
    dm_wdata[0] = 32'h11111111; ld_wdata[0] = 32'h33333333;
    for (int i = 0; i < 10; i++) begin
      drive();
      halted[0] = tab[i].halted; ld_req[0] = tab[i].ld_req; ld_we[0] = tab[i].ld_we;
      dm_req[0] = tab[i].dm_req; dm_we[0] = tab[i].dm_we; if_req[0] = tab[i].if_req;
      sample();
      chk($sformatf("tab%0d_gnt", i), {ld_gnt[0], dm_gnt[0], if_gnt[0]}, tab[i].gnt);
      chk($sformatf("tab%0d_en", i), mem_en[0], tab[i].mem_en);
      chk($sformatf("tab%0d_we", i), mem_we[0], tab[i].mem_we);
      chk($sformatf("tab%0d_addr", i), mem_addr[0], tab[i].mem_addr);
      if (tab[i].mem_we) begin
        exp_wd = tab[i].gnt[2] ? 32'h33333333 : 32'h11111111;
        chk($sformatf("tab%0d_wdata", i), mem_wdata[0], exp_wd);
      end
    end
    drive(); clr(0); halted[0] = 0;
  endtask

  // ---------------- random traffic vs. reference model -----------------------
  task automatic rand_run(input int k, input int lat, input int ncyc);
    logic [31:0] shm [1024];
    int          exp_own [$];
    logic [31:0] exp_dat [$];
    int          exp_due [$];
    int          free_at, starve, win, own;
    logic        if_done, dm_done, ld_done, we;
    logic [9:0]  addr;
    logic [31:0] wd, rd_act;
    logic [2:0]  gv, rv;
    for (int a = 0; a < 1024; a++) shm[a] = init_val(a);
    pulse_mem_init();
    reset_one(k);
    halted[k] = 1;
    free_at = 0; starve = 0;
    if_done = 0; dm_done = 0; ld_done = 0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      drive();
      if (if_done) if_req[k] = 0;
      if (dm_done) dm_req[k] = 0;
      if (ld_done) ld_req[k] = 0;
      if (if_req[k] && $urandom_range(0, 15) == 0) if_req[k] = 0;
      else if (!if_req[k] && $urandom_range(0, 2) == 0) begin
        if_req[k] = 1; if_addr[k] = 10'($urandom_range(0, 15));
      end
      if (dm_req[k] && $urandom_range(0, 15) == 0) dm_req[k] = 0;
      else if (!dm_req[k] && $urandom_range(0, 2) == 0) begin
        dm_req[k] = 1; dm_we[k] = 1'($urandom_range(0, 1));
        dm_addr[k] = 10'($urandom_range(0, 15)); dm_wdata[k] = $urandom;
      end
      if (!ld_req[k] && $urandom_range(0, 3) == 0) begin
        ld_req[k] = 1; ld_we[k] = 1'($urandom_range(0, 1));
        ld_addr[k] = 10'($urandom_range(0, 15)); ld_wdata[k] = $urandom;
      end
      if ($urandom_range(0, 9) == 0) halted[k] = ~halted[k];
      sample();

      win = 0;
      if (cyc >= free_at) begin
        if (ld_req[k] && halted[k])      win = 3;
        else if (if_req[k] && starve == 4) win = 1;
        else if (dm_req[k])              win = 2;
        else if (if_req[k])              win = 1;
      end
      gv = (win == 3) ? 3'b100 : (win == 2) ? 3'b010 : (win == 1) ? 3'b001 : 3'b000;
      chk("rnd_gnt", {ld_gnt[k], dm_gnt[k], if_gnt[k]}, gv);

      rv = 3'b000; own = 0;
      if (exp_due.size() > 0 && exp_due[0] == cyc) begin
        own = exp_own[0];
        rv[own-1] = 1'b1;
      end
      chk("rnd_rvalid", {ld_rvalid[k], dm_rvalid[k], if_rvalid[k]}, rv);
      if (own != 0) begin
        rd_act = (own == 1) ? if_rdata[k] : (own == 2) ? dm_rdata[k] : ld_rdata[k];
        chk("rnd_rdata", rd_act, exp_dat[0]);
        void'(exp_own.pop_front()); void'(exp_dat.pop_front()); void'(exp_due.pop_front());
      end

      if (win != 0) begin
        we   = (win == 1) ? 1'b0 : (win == 2) ? dm_we[k] : ld_we[k];
        addr = (win == 1) ? if_addr[k] : (win == 2) ? dm_addr[k] : ld_addr[k];
        wd   = (win == 2) ? dm_wdata[k] : ld_wdata[k];
        chk("rnd_maddr", mem_addr[k], addr);
        chk("rnd_mwe", mem_we[k], we);
        if (we) shm[addr] = wd;
        else begin
          exp_own.push_back(win); exp_dat.push_back(shm[addr]); exp_due.push_back(cyc + lat);
          free_at = cyc + lat;
        end
      end
      if (!if_req[k] || win == 1) starve = 0;
      else if (win == 2 && starve < 4) starve++;
      if_done = (win == 1); dm_done = (win == 2); ld_done = (win == 3);
    end
    drive(); clr(k); halted[k] = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic chk_starve;
    mem_init = 0;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1; halted[k] = 0; clr(k);
      if_addr[k] = 0; dm_addr[k] = 0; ld_addr[k] = 0; dm_wdata[k] = 0; ld_wdata[k] = 0;
    end
    pulse_mem_init();
    drive(); drive();
    for (int k = 0; k < 3; k++) rst[k] = 0;

    // reset state
    sample();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d_gnt", k), {ld_gnt[k], dm_gnt[k], if_gnt[k]}, 0);
      chk($sformatf("rst%0d_rvalid", k), {ld_rvalid[k], dm_rvalid[k], if_rvalid[k]}, 0);
      chk($sformatf("rst%0d_en_we_busy", k), {mem_en[k], mem_we[k], busy[k]}, 0);
      chk($sformatf("rst%0d_rdata", k), if_rdata[k] | dm_rdata[k] | ld_rdata[k], 0);
    end

    run_table();

    // A: MEM_LAT=1 write then read-back
    reset_one(0);
    drive(); dm_req[0] = 1; dm_we[0] = 1; dm_addr[0] = 5; dm_wdata[0] = 32'h2801000a;
    sample(); chk("a_wr_gnt", dm_gnt[0], 1); chk("a_wr_we", mem_we[0], 1);
              chk("a_wr_rvalid", dm_rvalid[0], 0);
    drive(); dm_we[0] = 0;
    sample(); chk("a_rd_gnt", dm_gnt[0], 1); chk("a_rd_we", mem_we[0], 0);
    drive(); dm_req[0] = 0;
    sample(); chk("a_rvalid", dm_rvalid[0], 1); chk("a_rdata", dm_rdata[0], 32'h2801000a);
    drive();
    sample(); chk("a_rvalid_pulse", dm_rvalid[0], 0); chk("a_rdata_hold", dm_rdata[0], 32'h2801000a);

    // C: loader gated by halted, then wins over dm
    drive(); halted[0] = 0; ld_req[0] = 1; ld_we[0] = 1; ld_addr[0] = 7; ld_wdata[0] = 32'h77;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      sample(); if (ld_gnt[0]) n++;
      drive();
    end
    chk("c_no_ld_gnt", n, 0);
    halted[0] = 1; dm_req[0] = 1; dm_we[0] = 1; dm_addr[0] = 9;
    sample(); chk("c_ld_gnt", ld_gnt[0], 1); chk("c_dm_wait", dm_gnt[0], 0);
    drive(); ld_req[0] = 0;
    sample(); chk("c_dm_gnt_after", dm_gnt[0], 1);
    drive(); clr(0); halted[0] = 0;

    // D: starvation pattern dm x4 then if
    drive(); dm_req[0] = 1; dm_we[0] = 1; dm_addr[0] = 9; if_req[0] = 1; if_addr[0] = 2;
    chk_starve = 0;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) drive();
      sample();
      if (chk_starve) chk($sformatf("d_starve_clr%0d", i), 32'(g_dut[0].u_dut.starve_cnt), 0);
      chk($sformatf("d_if_gnt%0d", i), if_gnt[0], (i % 5 == 4) ? 1 : 0);
      chk($sformatf("d_dm_gnt%0d", i), dm_gnt[0], (i % 5 == 4) ? 0 : 1);
      chk_starve = (i % 5 == 4);
    end
    drive(); clr(0);

    // B: MEM_LAT=3, if and dm together
    drive(); if_req[1] = 1; if_addr[1] = 0; dm_req[1] = 1; dm_we[1] = 0; dm_addr[1] = 8;
    sample(); chk("b_dm_gnt", dm_gnt[1], 1); chk("b_if_wait", if_gnt[1], 0);
    for (int i = 1; i <= 6; i++) begin
      drive();
      if (i == 1) dm_req[1] = 0;
      if (i == 4) if_req[1] = 0;
      sample();
      if (i < 3) begin
        chk($sformatf("b_busy%0d", i), busy[1], 1);
        chk($sformatf("b_nognt%0d", i), {dm_gnt[1], if_gnt[1]}, 0);
      end
      if (i == 3) begin
        chk("b_dm_rvalid", dm_rvalid[1], 1); chk("b_dm_rdata", dm_rdata[1], init_val(8));
        chk("b_if_gnt", if_gnt[1], 1); chk("b_busy_last", busy[1], 0);
      end
      if (i == 4 || i == 5) chk($sformatf("b_if_early%0d", i), if_rvalid[1], 0);
      if (i == 6) begin
        chk("b_if_rvalid", if_rvalid[1], 1); chk("b_if_rdata", if_rdata[1], init_val(0));
      end
    end

    // F: halted falls during a loader read
    drive(); halted[1] = 1; ld_req[1] = 1; ld_we[1] = 0; ld_addr[1] = 12;
    sample(); chk("f_ld_gnt", ld_gnt[1], 1);
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      drive();
      if (i == 1) begin halted[1] = 0; ld_addr[1] = 13; end
      sample();
      if (ld_gnt[1]) n++;
      if (i == 3) begin
        chk("f_ld_rvalid", ld_rvalid[1], 1); chk("f_ld_rdata", ld_rdata[1], init_val(12));
      end
    end
    chk("f_no_more_ld_gnt", n, 0);
    drive(); clr(1);

    // E: MEM_LAT=4, reset abandons an outstanding read
    drive(); dm_req[2] = 1; dm_we[2] = 0; dm_addr[2] = 3;
    sample(); chk("e_gnt", dm_gnt[2], 1);
    n = 0;
    for (int i = 1; i <= 7; i++) begin
      drive();
      if (i == 1) dm_req[2] = 0;
      if (i == 2) rst[2] = 1;
      if (i == 3) begin rst[2] = 0; dm_req[2] = 1; dm_addr[2] = 6; end
      if (i == 4) dm_req[2] = 0;
      sample();
      if (i <= 6 && dm_rvalid[2]) n++;
      if (i == 1) chk("e_busy", busy[2], 1);
      if (i == 3) begin chk("e_busy_after_rst", busy[2], 0); chk("e_regrant", dm_gnt[2], 1); end
      if (i == 7) begin
        chk("e_new_rvalid", dm_rvalid[2], 1); chk("e_new_rdata", dm_rdata[2], init_val(6));
      end
    end
    chk("e_no_stale_rvalid", n, 0);
    drive(); clr(2);

    rand_run(0, 1, 500);
    rand_run(1, 3, 500);
    rand_run(2, 4, 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips32_mem_arbiter.md
# mips32_mem_arbiter

Single-port memory arbiter for the two-stage-clocked MIPS32 pipeline. It shares one synchronous word-addressed memory between three requesters: the instruction-fetch stage, the MEM-stage data access, and a host program loader. The loader is serviced only while the core reports HALTED. The arbiter sequences every access, tracks the one outstanding read, and returns read data to its owner.

## Interface
- AW, 10, word-address width
- DW, 32, data width
- MEM_LAT, 1, cycles from read issue to valid `mem_rdata`; legal 1..4
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits

Ports:
- clk1  in  1  sole clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- halted  in  1  core HALTED flag; gates loader eligibility
- if_req, if_addr  in  1, AW  fetch read request; held until `if_gnt`
- if_gnt, if_rvalid  out  1, 1  grant pulse; read-data-valid pulse
- if_rdata  out  DW  fetch read data, valid with `if_rvalid`
- dm_req, dm_we, dm_addr, dm_wdata  in  1, 1, AW, DW  data request; held until `dm_gnt`
- dm_gnt, dm_rvalid  out  1, 1
- dm_rdata  out  DW
- ld_req, ld_we, ld_addr, ld_wdata  in  1, 1, AW, DW  loader request; held until `ld_gnt`
- ld_gnt, ld_rvalid  out  1, 1
- ld_rdata  out  DW
- mem_en, mem_we, mem_addr, mem_wdata  out  1, 1, AW, DW  memory command
- mem_rdata  in  DW  valid MEM_LAT cycles after a read command
- busy  out  1  read outstanding

## Operation
- FSM states:
  - IDLE: the arbiter can grant.
  - RD_WAIT: one read is outstanding; a latency counter runs and the owner register records which requester issued the read.
- Eligibility:
  - ld: `ld_req & halted`.
  - dm: `dm_req`.
  - if: `if_req`.
- Priority is ld > dm > if, with one override. When the starve counter equals STARVE_MAX and `if_req` is high, if wins over dm. The override never applies against ld.
- Starve counter:
  - It increments on each dm grant while `if_req` is high, and saturates at STARVE_MAX.
  - It clears on any if grant, or in any cycle where `if_req` is low.
- Grant cycle:
  - Exactly one `*_gnt` is asserted, combinationally, in a cycle where the arbiter can grant.
  - `mem_en` = 1 in the grant cycle, with the winner's `we/addr/wdata` forwarded to the memory.
  - Fetch is always a read (`mem_we` = 0).
- Writes complete in the grant cycle. They produce no rvalid and the FSM stays in IDLE, so back-to-back writes go out one per cycle.
- Reads:
  - On a read grant the FSM enters RD_WAIT with the counter loaded to MEM_LAT-1.
  - When the counter reaches 0, the owner's `*_rvalid` pulses for one cycle with `*_rdata` = `mem_rdata`.
  - The FSM can grant again in that same rvalid cycle (read-to-read spacing is MEM_LAT).
- Non-owner rdata outputs hold their last value. Only rvalid qualifies rdata.
- `halted` falling while a loader read is outstanding: the read completes and `ld_rvalid` still pulses. Any further ld requests become ineligible.
- `busy` = 1 exactly when the FSM is in RD_WAIT and not in its final (rvalid) cycle.

## Timing
- Reset values: all `*_gnt` and `*_rvalid` = 0; `mem_en` = 0; `mem_we` = 0; `busy` = 0; all rdata = 0. FSM = IDLE, starve counter = 0, owner = none.
- `rst` asserted in RD_WAIT abandons the read:
  - No rvalid is produced.
  - A late `mem_rdata` is ignored.
  - The first grant is possible in the first cycle after `rst` deasserts.
- Read latency: a grant at cycle t gives `*_rvalid` at t+MEM_LAT. Write latency is 0 (the grant cycle itself).
- Request rules:
  - A requester samples `*_gnt` in the same cycle.
  - A request dropped before its grant is legal and is simply not served.
  - `*_addr`/`*_wdata` may change only after the grant.
- No grant is issued during RD_WAIT except in its final cycle.
- Simultaneous ld/dm/if requests in the same cycle resolve by the priority above. Losers wait with no loss of request.

## Structure
- Package `mips32_mem_pkg`:
  - AW/DW default constants.
  - `owner_t` enum {OWN_NONE, OWN_IF, OWN_DM, OWN_LD}.
  - `arb_state_t` enum {ST_IDLE, ST_RD_WAIT}.
- One combinational sub-module, `mips32_mem_pick`. It takes the three eligibility bits and the starve-override flag and returns the `owner_t` winner.
- The FSM, latency counter, starve counter and the owner/rdata routing live in the top module.

## Test plan
- MEM_LAT=1: dm write addr 5 data 0x2801000a, then a dm read of addr 5. Expect `dm_gnt` in each request cycle, then `dm_rvalid` one cycle after the read grant with `dm_rdata`=0x2801000a.
- MEM_LAT=3: an if read of addr 0 and a dm read of addr 8 arrive in the same cycle. Expect dm granted at t and `dm_rvalid` at t+3, then if granted at t+3 and `if_rvalid` at t+6.
- `halted`=0 with `ld_req` held 10 cycles: expect no `ld_gnt`. Raise `halted`=1: expect `ld_gnt` in that cycle, winning over a pending `dm_req`.
- STARVE_MAX=4, MEM_LAT=1, dm and if both requesting continuously: expect the pattern dm,dm,dm,dm,if repeating. Expect the starve counter at 0 after each if grant.
- MEM_LAT=4: dm read granted, then `rst` pulsed at grant+2. Expect no `dm_rvalid`, `busy`=0 after reset, and a fresh grant possible in the cycle after `rst` falls.
- Loader read in progress with `halted` falling mid-read: expect `ld_rvalid` at grant+MEM_LAT and no subsequent `ld_gnt`.
